// File: rtl/brq_iccm_loader_if.sv
// Byte-stream and ICCM write-port bundle for brq_iccm_loader.
// The master side is the loader: it consumes stream bytes and drives the ICCM write port.
interface brq_iccm_loader_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 15
);
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic                 iccm_write;
    logic [AddrWidth-1:0] iccm_address;
    logic [DataWidth-1:0] iccm_data;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output iccm_write,
        output iccm_address,
        output iccm_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  iccm_write,
        input  iccm_address,
        input  iccm_data
    );
endinterface

// File: rtl/brq_iccm_loader.sv
// Boot loader: packs a length-prefixed little-endian byte stream into ICCM words and holds
// the core in reset until the image is in. Define BRQ_LOADER_CHECKSUM_EN for a trailing XOR byte.
module brq_iccm_loader #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 15,
    parameter int BaseAddr  = 0
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic                 start,
    brq_iccm_loader_if.master    bus,
    output logic                 core_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 load_error,
    output logic [AddrWidth:0]   words_loaded
);
    // Largest word count that still fits between BaseAddr and the top of the ICCM.
    localparam logic [32:0] MaxWords = (33'd1 << AddrWidth) - 33'(BaseAddr);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         byte_cnt;
    logic [23:0]        shift;
    logic [AddrWidth:0] n_words;
    logic [31:0]        rx_word;
    logic               beat;
    logic               word_last_byte;
    logic               len_zero;
    logic               len_overflow;
    logic               last_word;
`ifdef BRQ_LOADER_CHECKSUM_EN
    logic [7:0]         chk;
`endif

    assign beat           = bus.rx_valid && bus.rx_ready;
    assign word_last_byte = beat && (byte_cnt == 2'd3);
    // Earlier bytes sit in shift; the byte on the bus completes the little-endian word.
    assign rx_word        = {bus.rx_data, shift};
    assign len_zero       = (rx_word == 32'd0);
    assign len_overflow   = ({1'b0, rx_word} > MaxWords);
    assign last_word      = ((words_loaded + (AddrWidth+1)'(1)) == n_words);

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        bus.rx_ready   = 1'b0;
        bus.iccm_write = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        load_error     = 1'b0;
        core_hold      = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_next = LEN;
            end
            LEN: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (word_last_byte) begin
                    if (len_zero) begin
`ifdef BRQ_LOADER_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = DONE;
`endif
                    end else if (len_overflow) begin
                        state_next = ERROR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (word_last_byte) state_next = WRITE;
            end
            WRITE: begin
                bus.iccm_write = 1'b1;
                busy           = 1'b1;
                if (last_word) begin
`ifdef BRQ_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = DATA;
                end
            end
`ifdef BRQ_LOADER_CHECKSUM_EN
            CHECK: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (beat) state_next = (bus.rx_data == chk) ? DONE : ERROR;
            end
`endif
            DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
                if (start) state_next = LEN;
            end
            ERROR: begin
                load_error = 1'b1;
                if (start) state_next = LEN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            byte_cnt         <= 2'd0;
            shift            <= 24'd0;
            n_words          <= '0;
            words_loaded     <= '0;
            bus.iccm_address <= '0;
            bus.iccm_data    <= '0;
`ifdef BRQ_LOADER_CHECKSUM_EN
            chk              <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        byte_cnt     <= 2'd0;
                        words_loaded <= '0;
`ifdef BRQ_LOADER_CHECKSUM_EN
                        chk          <= 8'd0;
`endif
                    end
                end
                LEN, DATA: begin
                    if (beat) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= rx_word[31:8];
`ifdef BRQ_LOADER_CHECKSUM_EN
                        chk      <= chk ^ bus.rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            if (state == LEN) begin
                                n_words <= rx_word[AddrWidth:0];
                            end else begin
                                bus.iccm_data    <= rx_word;
                                bus.iccm_address <= AddrWidth'(BaseAddr) + words_loaded[AddrWidth-1:0];
                            end
                        end
                    end
                end
                WRITE: begin
                    words_loaded <= words_loaded + (AddrWidth+1)'(1);
                    byte_cnt     <= 2'd0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_brq_iccm_loader.sv
// Randomized self-checking bench for brq_iccm_loader; expected ICCM contents are derived from the
// word lists the bench generates. Works with or without BRQ_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_brq_iccm_loader;
    localparam int AW   = 15;
    localparam int DW   = 32;
    localparam int BASE = 0;
`ifdef BRQ_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic brq_clk = 1'b0;
    logic brq_rst = 1'b0;
    logic start   = 1'b0;
    logic core_hold, busy, done, load_error;
    logic [AW:0] words_loaded;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];

    brq_iccm_loader_if #(.DataWidth(DW), .AddrWidth(AW)) bus();

    brq_iccm_loader #(.DataWidth(DW), .AddrWidth(AW), .BaseAddr(BASE)) dut (
        .brq_clk      (brq_clk),
        .brq_rst      (brq_rst),
        .start        (start),
        .bus          (bus),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 brq_clk = ~brq_clk;

    // Write monitor: logs every ICCM write and requires the stream to be stalled while writing.
    always @(negedge brq_clk) begin
        if (bus.iccm_write === 1'b1) begin
            wr_addr.push_back(bus.iccm_address);
            wr_data.push_back(bus.iccm_data);
            checks++;
            if (bus.rx_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write: rx_ready=%b required 0", bus.rx_ready);
            end
        end
    end

    function automatic void build_stream(input logic [31:0] n, input logic [31:0] words[$],
                                         input bit add_chk, output logic [7:0] s[$]);
        logic [7:0] x;
        logic [31:0] w;
        s.delete();
        for (int b = 0; b < 4; b++) s.push_back(n[8*b +: 8]);
        foreach (words[i]) begin
            w = words[i];
            for (int b = 0; b < 4; b++) s.push_back(w[8*b +: 8]);
        end
        if (add_chk) begin
            x = 8'h00;
            foreach (s[i]) x ^= s[i];
            s.push_back(x);
        end
    endfunction

    task automatic apply_reset();
        brq_rst      = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge brq_clk);
        #1;
        brq_rst = 1'b1;
        @(posedge brq_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge brq_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input int gap, input bit rnd);
        int idle;
        int waited;
        bit ok;
        idle = rnd ? int'($urandom_range(gap, 0)) : gap;
        repeat (idle) begin
            bus.rx_valid = 1'b0;
            @(posedge brq_clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        waited = 0;
        do begin
            ok = bus.rx_ready;
            @(posedge brq_clk);
            #1;
            waited++;
        end while (!ok && waited < 200);
        bus.rx_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout: byte %h not accepted within 200 cycles", b);
        end
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int gap, input bit rnd);
        foreach (s[i]) push_byte(s[i], gap, rnd);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({core_hold, busy, done, load_error, bus.iccm_write, bus.rx_ready} !== 6'b100000 ||
            words_loaded !== '0 || bus.iccm_address !== '0 || bus.iccm_data !== '0) begin
            errors++;
            $display("FAIL reset_values: hold/busy/done/err/wr/rdy=%b wl=%0d addr=%h data=%h required 100000 0 0 0",
                     {core_hold, busy, done, load_error, bus.iccm_write, bus.rx_ready},
                     words_loaded, bus.iccm_address, bus.iccm_data);
        end
    endtask

    task automatic test_basic();
        logic [31:0] words[$];
        logic [7:0]  s[$];
        words = '{32'h00A00513, 32'h0000006F};
        build_stream(32'd2, words, CHK, s);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        checks++;
        if (bus.rx_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: rx_ready=%b busy=%b required 1 1", bus.rx_ready, busy);
        end
        send_stream(s, 0, 1'b0);
        if (!CHK) begin
            checks++;
            if (bus.iccm_write !== 1'b1 || bus.iccm_address !== AW'(BASE + 1) || bus.iccm_data !== 32'h0000006F) begin
                errors++;
                $display("FAIL write_latency: wr=%b addr=%h data=%h required 1 %h 0000006f",
                         bus.iccm_write, bus.iccm_address, bus.iccm_data, AW'(BASE + 1));
            end
            @(posedge brq_clk);
            #1;
        end
        checks++;
        if (done !== 1'b1 || core_hold !== 1'b0 || busy !== 1'b0 || words_loaded !== 16'd2) begin
            errors++;
            $display("FAIL basic_done: done=%b hold=%b busy=%b wl=%0d required 1 0 0 2",
                     done, core_hold, busy, words_loaded);
        end
        checks++;
        if (wr_addr.size() != 2 || wr_addr[0] !== AW'(BASE) || wr_data[0] !== 32'h00A00513 ||
            wr_addr[1] !== AW'(BASE + 1) || wr_data[1] !== 32'h0000006F) begin
            errors++;
            $display("FAIL basic_writes: count=%0d first=%h@%h required 2 writes 00a00513@0 0000006f@1",
                     wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'hx,
                     (wr_addr.size() > 0) ? wr_addr[0] : AW'('x));
        end
    endtask

    task automatic test_overflow();
        logic [31:0] lens[2];
        logic [31:0] none[$];
        logic [7:0]  s[$];
        lens[0] = 32'h0000_8001;
        lens[1] = 32'hFFFF_FFFF;
        wr_addr.delete();
        for (int k = 0; k < 2; k++) begin
            build_stream(lens[k], none, 1'b0, s);
            pulse_start();
            checks++;
            if (load_error !== 1'b0 || done !== 1'b0 || core_hold !== 1'b1) begin
                errors++;
                $display("FAIL restart_clears: err=%b done=%b hold=%b required 0 0 1", load_error, done, core_hold);
            end
            send_stream(s, 1, 1'b1);
            checks++;
            if (load_error !== 1'b1 || core_hold !== 1'b1 || busy !== 1'b0 || bus.rx_ready !== 1'b0) begin
                errors++;
                $display("FAIL overflow_%0d: err=%b hold=%b busy=%b rdy=%b required 1 1 0 0",
                         k, load_error, core_hold, busy, bus.rx_ready);
            end
        end
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL overflow_writes: count=%0d required 0", wr_addr.size());
        end
        // Exactly 2^AW words fills the ICCM from BASE=0 and must be accepted.
        build_stream(32'h0000_8000, none, 1'b0, s);
        pulse_start();
        send_stream(s, 0, 1'b0);
        checks++;
        if (load_error !== 1'b0 || busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_size_len: err=%b busy=%b rdy=%b required 0 1 1", load_error, busy, bus.rx_ready);
        end
        apply_reset();
    endtask

    task automatic test_throttle();
        logic [31:0] words[$];
        logic [7:0]  s[$];
        words = '{$urandom()};
        build_stream(32'd1, words, CHK, s);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_stream(s, 1, 1'b0);
        repeat (2) @(posedge brq_clk);
        #1;
        checks++;
        if (wr_addr.size() != 1 || wr_data[0] !== words[0] || wr_addr[0] !== AW'(BASE) || done !== 1'b1) begin
            errors++;
            $display("FAIL throttle: writes=%0d data=%h done=%b required 1 %h 1",
                     wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'hx, done, words[0]);
        end
    endtask

    task automatic test_midload_reset();
        logic [31:0] words[$];
        logic [7:0]  s[$];
        for (int i = 0; i < 3; i++) words.push_back($urandom());
        build_stream(32'd3, words, CHK, s);
        pulse_start();
        for (int i = 0; i < 12; i++) push_byte(s[i], 2, 1'b1);
        @(posedge brq_clk);
        #1;
        brq_rst = 1'b0;
        @(posedge brq_clk);
        #1;
        checks++;
        if ({core_hold, busy, done, load_error, bus.iccm_write, bus.rx_ready} !== 6'b100000 ||
            words_loaded !== '0 || bus.iccm_address !== '0 || bus.iccm_data !== '0) begin
            errors++;
            $display("FAIL midload_reset: flags=%b wl=%0d addr=%h data=%h required 100000 0 0 0",
                     {core_hold, busy, done, load_error, bus.iccm_write, bus.rx_ready},
                     words_loaded, bus.iccm_address, bus.iccm_data);
        end
        brq_rst = 1'b1;
        @(posedge brq_clk);
        #1;
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_stream(s, 0, 1'b0);
        repeat (2) @(posedge brq_clk);
        #1;
        checks++;
        if (wr_addr.size() != 3 || done !== 1'b1 || words_loaded !== 16'd3) begin
            errors++;
            $display("FAIL reload_count: writes=%0d done=%b wl=%0d required 3 1 3", wr_addr.size(), done, words_loaded);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr[i] !== AW'(BASE + i) || wr_data[i] !== words[i]) begin
                    errors++;
                    $display("FAIL reload_word%0d: %h@%h required %h@%h", i, wr_data[i], wr_addr[i], words[i], AW'(BASE + i));
                end
            end
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] none[$];
        logic [7:0]  s[$];
        build_stream(32'd0, none, CHK, s);
        wr_addr.delete();
        pulse_start();
        send_stream(s, 0, 1'b0);
        checks++;
        if (done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== '0 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: done=%b hold=%b wl=%0d err=%b required 1 0 0 0", done, core_hold, words_loaded, load_error);
        end
        @(posedge brq_clk);
        #1;
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL zero_len_writes: count=%0d required 0", wr_addr.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[$];
        logic [7:0]  s[$];
        int n;
        for (int load = 0; load < 5; load++) begin
            words.delete();
            n = int'($urandom_range(8, 1));
            for (int i = 0; i < n; i++) words.push_back($urandom());
            build_stream(32'(n), words, CHK, s);
            wr_addr.delete();
            wr_data.delete();
            // Start arrives together with the first length byte; that byte must survive.
            start        = 1'b1;
            bus.rx_valid = 1'b1;
            bus.rx_data  = s[0];
            @(posedge brq_clk);
            #1;
            start = 1'b0;
            checks++;
            if (done !== 1'b0 || core_hold !== 1'b1 || words_loaded !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL restart_state: done=%b hold=%b wl=%0d busy=%b required 0 1 0 1",
                         done, core_hold, words_loaded, busy);
            end
            for (int i = 0; i < s.size(); i++) begin
                if (i == 6) begin
                    bus.rx_valid = 1'b0;
                    pulse_start();
                end
                push_byte(s[i], 3, 1'b1);
            end
            repeat (2) @(posedge brq_clk);
            #1;
            checks++;
            if (wr_addr.size() != n || done !== 1'b1 || words_loaded !== (AW+1)'(n)) begin
                errors++;
                $display("FAIL b2b_count%0d: writes=%0d done=%b wl=%0d required %0d 1 %0d",
                         load, wr_addr.size(), done, words_loaded, n, n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (wr_addr[i] !== AW'(BASE + i) || wr_data[i] !== words[i]) begin
                        errors++;
                        $display("FAIL b2b_word%0d_%0d: %h@%h required %h@%h",
                                 load, i, wr_data[i], wr_addr[i], words[i], AW'(BASE + i));
                    end
                end
            end
        end
    endtask

`ifdef BRQ_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] s[$];
        logic [7:0] tail[2];
        tail[0] = 8'h45;
        tail[1] = 8'h46;
        for (int k = 0; k < 2; k++) begin
            s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
            s.push_back(tail[k]);
            pulse_start();
            send_stream(s, 1, 1'b1);
            checks++;
            if (done !== (k == 0) || load_error !== (k == 1) || core_hold !== (k == 1)) begin
                errors++;
                $display("FAIL checksum_%h: done=%b err=%b hold=%b required %b %b %b",
                         tail[k], done, load_error, core_hold, k == 0, k == 1, k == 1);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_throttle();
        test_midload_reset();
        test_back_to_back();
`ifdef BRQ_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
